// File: rtl/motor_sensor_emulator.sv
// ---------------------------------------------------------------------------
// motor_sensor_emulator
//
// Virtual rotor for hardware-in-the-loop benches. A phase accumulator
// {theta, frac} advances by a signed Q0.F speed each enabled cycle. The
// emulator produces hall UVW, quadrature A/B/Z and step pulses that match
// the electrical-angle convention of the rotor position estimator.
//
// Optional feature macro: MOTOR_SENSOR_EMULATOR_FAULT_EN adds the
// fault_mode port, which can override hall_uvw for fault injection.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   enable      in   rotor advances only while high
//   speed       in   signed counts/cycle, Q0.F (F = SPEED_WIDTH-1)
//   load_valid  in   one-cycle strobe; loads load_theta, clears frac
//   load_theta  in   position to load
//   fault_mode  in   (FAULT_EN only) 00 normal, 01 hall=000,
//                    10 hall=111, 11 hall frozen
//   theta       out  current rotor position
//   step_inc    out  one-cycle pulse when theta moves +1
//   step_dec    out  one-cycle pulse when theta moves -1
//   enc_a/b/z   out  quadrature outputs and index (z high at theta==0)
//   hall_uvw    out  hall outputs {U,V,W}
//
// load_valid is a plain strobe with no ready: it is accepted in every
// cycle it is high, and it takes priority over enable.
// ---------------------------------------------------------------------------
module motor_sensor_emulator #(
  parameter int THETA_WIDTH = 9,
  parameter int SPEED_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [SPEED_WIDTH-1:0] speed,
  input  logic                   load_valid,
  input  logic [THETA_WIDTH-1:0] load_theta,
`ifdef MOTOR_SENSOR_EMULATOR_FAULT_EN
  input  logic [1:0]             fault_mode,
`endif
  output logic [THETA_WIDTH-1:0] theta,
  output logic                   step_inc,
  output logic                   step_dec,
  output logic                   enc_a,
  output logic                   enc_b,
  output logic                   enc_z,
  output logic [2:0]             hall_uvw
);

  localparam int F  = SPEED_WIDTH - 1;
  localparam int AW = THETA_WIDTH + F;
  localparam int P  = 1 << THETA_WIDTH;

  // Hall sector boundaries b_k = ((2k+1)*P)/12.
  localparam logic [THETA_WIDTH-1:0] B0 = THETA_WIDTH'((1 * P) / 12);
  localparam logic [THETA_WIDTH-1:0] B1 = THETA_WIDTH'((3 * P) / 12);
  localparam logic [THETA_WIDTH-1:0] B2 = THETA_WIDTH'((5 * P) / 12);
  localparam logic [THETA_WIDTH-1:0] B3 = THETA_WIDTH'((7 * P) / 12);
  localparam logic [THETA_WIDTH-1:0] B4 = THETA_WIDTH'((9 * P) / 12);
  localparam logic [THETA_WIDTH-1:0] B5 = THETA_WIDTH'((11 * P) / 12);

  logic [F-1:0]           frac;
  logic [SPEED_WIDTH-1:0] speed_sat;
  logic [AW-1:0]          speed_ext;
  logic [AW-1:0]          acc_next;
  logic [THETA_WIDTH-1:0] theta_next;
  logic                   inc_next;
  logic                   dec_next;
  logic [2:0]             hall_map;
  logic [2:0]             hall_next;

  always_comb begin
    // The most negative speed is pulled in by one LSB so a step is always
    // strictly below one count; theta can then move at most one per cycle.
    speed_sat = speed;
    if (speed == {1'b1, {F{1'b0}}}) begin
      speed_sat = {1'b1, {(F-1){1'b0}}, 1'b1};
    end
    speed_ext = {{THETA_WIDTH{speed_sat[SPEED_WIDTH-1]}}, speed_sat[F-1:0]};

    acc_next = {theta, frac};
    inc_next = 1'b0;
    dec_next = 1'b0;
    if (load_valid) begin
      acc_next = {load_theta, {F{1'b0}}};
    end else if (enable) begin
      acc_next = {theta, frac} + speed_ext;
      // With |step| < 1 any change of theta is exactly one count in the
      // direction of the speed sign, wraps included.
      if (acc_next[AW-1:F] != theta) begin
        inc_next = ~speed_sat[SPEED_WIDTH-1];
        dec_next = speed_sat[SPEED_WIDTH-1];
      end
    end
    theta_next = acc_next[AW-1:F];

    if      (theta_next < B0) hall_map = 3'b110;
    else if (theta_next < B1) hall_map = 3'b010;
    else if (theta_next < B2) hall_map = 3'b011;
    else if (theta_next < B3) hall_map = 3'b001;
    else if (theta_next < B4) hall_map = 3'b101;
    else if (theta_next < B5) hall_map = 3'b100;
    else                      hall_map = 3'b110;
  end

`ifdef MOTOR_SENSOR_EMULATOR_FAULT_EN
  // Last hall code produced while not frozen; mode 11 replays it.
  logic [2:0] hall_held;

  always_comb begin
    case (fault_mode)
      2'b00:   hall_next = hall_map;
      2'b01:   hall_next = 3'b000;
      2'b10:   hall_next = 3'b111;
      default: hall_next = hall_held;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hall_held <= 3'b110;
    end else if (fault_mode != 2'b11) begin
      hall_held <= hall_map;
    end
  end
`else
  always_comb begin
    hall_next = hall_map;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      theta    <= '0;
      frac     <= '0;
      step_inc <= 1'b0;
      step_dec <= 1'b0;
      enc_a    <= 1'b0;
      enc_b    <= 1'b0;
      enc_z    <= 1'b1;
      hall_uvw <= 3'b110;
    end else begin
      theta    <= theta_next;
      frac     <= acc_next[F-1:0];
      step_inc <= inc_next;
      step_dec <= dec_next;
      // Gray sequence 00,01,11,10 over theta[1:0]: B leads A going up.
      enc_a    <= theta_next[1];
      enc_b    <= theta_next[1] ^ theta_next[0];
      enc_z    <= (theta_next == '0);
      hall_uvw <= hall_next;
    end
  end

endmodule

// File: tb/tb_motor_sensor_emulator.sv
// ---------------------------------------------------------------------------
// tb_motor_sensor_emulator
//
// Testbench for motor_sensor_emulator (THETA_WIDTH=9, SPEED_WIDTH=16).
// A reference model of the accumulator and sensor mapping predicts the full
// output vector {theta, step_inc, step_dec, a, b, z, hall} for every cycle
// driven. The prediction is pushed to exp_q and popped once the DUT has
// updated. Scenario tasks add targeted checks on top of that.
// ---------------------------------------------------------------------------
module tb_motor_sensor_emulator;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] speed;
  logic        load_valid;
  logic [8:0]  load_theta;
  logic [1:0]  fault_mode;
  logic [8:0]  theta;
  logic        step_inc, step_dec, enc_a, enc_b, enc_z;
  logic [2:0]  hall_uvw;

  always #5 clk = ~clk;

  motor_sensor_emulator #(.THETA_WIDTH(9), .SPEED_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .speed      (speed),
    .load_valid (load_valid),
    .load_theta (load_theta),
`ifdef MOTOR_SENSOR_EMULATOR_FAULT_EN
    .fault_mode (fault_mode),
`endif
    .theta      (theta),
    .step_inc   (step_inc),
    .step_dec   (step_dec),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_z      (enc_z),
    .hall_uvw   (hall_uvw)
  );

  logic [16:0] obs;
  assign obs = {theta, step_inc, step_dec, enc_a, enc_b, enc_z, hall_uvw};

  // ---------------- scoreboard / model ----------------
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  logic [23:0] m_acc  = '0;
  logic [2:0]  m_held = 3'b110;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [2:0] m_hall(input logic [8:0] t);
    if      (t < 9'd42)  return 3'b110;
    else if (t < 9'd128) return 3'b010;
    else if (t < 9'd213) return 3'b011;
    else if (t < 9'd298) return 3'b001;
    else if (t < 9'd384) return 3'b101;
    else if (t < 9'd469) return 3'b100;
    else                 return 3'b110;
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs, predicts the outputs after the next edge,
  // then advances to 1 ns past that edge.
  task automatic drive(input logic rst, input logic en, input logic [15:0] spd,
                       input logic lv, input logic [8:0] lt);
    logic [8:0]  old_t, nt;
    logic [15:0] s;
    logic        inc, dec;
    logic [2:0]  h, eh;
    reset = rst; enable = en; speed = spd; load_valid = lv; load_theta = lt;
    old_t = m_acc[23:15];
    inc = 1'b0;
    dec = 1'b0;
    if (rst) begin
      m_acc = '0;
    end else if (lv) begin
      m_acc = {lt, 15'd0};
    end else if (en) begin
      s = (spd == 16'h8000) ? 16'h8001 : spd;
      m_acc = m_acc + {{8{s[15]}}, s};
      nt = m_acc[23:15];
      if (nt == old_t + 9'd1) inc = 1'b1;
      if (nt == old_t - 9'd1) dec = 1'b1;
    end
    nt = m_acc[23:15];
    h  = m_hall(nt);
    eh = h;
`ifdef MOTOR_SENSOR_EMULATOR_FAULT_EN
    case (fault_mode)
      2'b01:   eh = 3'b000;
      2'b10:   eh = 3'b111;
      2'b11:   eh = m_held;
      default: eh = h;
    endcase
    if (fault_mode != 2'b11) m_held = h;
`endif
    if (rst) begin
      eh = 3'b110;
      m_held = 3'b110;
    end
    exp_q.push_back({nt, inc, dec, nt[1], nt[1] ^ nt[0], (nt == 9'd0), eh});
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    fault_mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 16'd20000, 1'b1, 9'd77);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_sb got %h want %h", obs, exp_v);
      end
    end
    checks++;
    if ({theta, step_inc, step_dec, enc_a, enc_b, enc_z, hall_uvw} !==
        {9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110}) begin
      errors++;
      $display("FAIL reset_values got theta=%0d inc=%b dec=%b a=%b b=%b z=%b hall=%b want 0 0 0 0 0 1 110",
               theta, step_inc, step_dec, enc_a, enc_b, enc_z, hall_uvw);
    end
  endtask

  task automatic test_rotation();
    logic [8:0] bnd[6] = '{9'd42, 9'd128, 9'd213, 9'd298, 9'd384, 9'd469};
    logic [8:0] chg_q[$];
    logic [2:0] prev_h;
    int n_inc = 0, n_z = 0, n_bad = 0;
    prev_h = hall_uvw;
    for (int i = 0; i < 1024; i++) begin
      drive(1'b0, 1'b1, 16'd16384, 1'b0, 9'd0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rotation_sb cycle %0d got %h want %h", i, obs, exp_v);
      end
      if (step_inc) n_inc++;
      if (enc_z) n_z++;
      if (hall_uvw !== prev_h) begin
        chg_q.push_back(theta);
        if ($countones(hall_uvw ^ prev_h) != 1) n_bad++;
      end
      prev_h = hall_uvw;
    end
    checks++;
    if (theta !== 9'd0) begin
      errors++;
      $display("FAIL rotation_wrap got theta=%0d want 0", theta);
    end
    checks++;
    if (n_inc != 512 || n_z != 2) begin
      errors++;
      $display("FAIL rotation_counts got inc=%0d z=%0d want 512 2", n_inc, n_z);
    end
    checks++;
    if (chg_q.size() != 6 || n_bad != 0) begin
      errors++;
      $display("FAIL hall_changes got %0d changes %0d multi-bit want 6 0", chg_q.size(), n_bad);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (chg_q[k] !== bnd[k]) begin
          errors++;
          $display("FAIL hall_boundary %0d got theta=%0d want %0d", k, chg_q[k], bnd[k]);
        end
      end
    end
  endtask

  task automatic test_neg_saturation();
    drive(1'b1, 1'b0, 16'd0, 1'b0, 9'd0);
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 32768; i++) begin
      drive(1'b0, 1'b1, 16'h8000, 1'b0, 9'd0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL negsat_sb cycle %0d got %h want %h", i, obs, exp_v);
      end
      if (i == 0) begin
        checks++;
        if ({step_dec, step_inc, theta, enc_a, enc_b, hall_uvw} !==
            {1'b1, 1'b0, 9'd511, 1'b1, 1'b0, 3'b110}) begin
          errors++;
          $display("FAIL negsat_first got dec=%b inc=%b theta=%0d a=%b b=%b hall=%b want 1 0 511 1 0 110",
                   step_dec, step_inc, theta, enc_a, enc_b, hall_uvw);
        end
      end
    end
    // -32767 loses one count every 32768 cycles relative to -32768.
    checks++;
    if (theta !== 9'd1 || step_dec !== 1'b0) begin
      errors++;
      $display("FAIL negsat_drift got theta=%0d dec=%b want 1 0", theta, step_dec);
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 16'd32767, 1'b1, 9'd127);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || theta !== 9'd127 || hall_uvw !== 3'b010 || step_inc || step_dec) begin
      errors++;
      $display("FAIL load_prio got %h theta=%0d hall=%b want %h 127 010", obs, theta, hall_uvw, exp_v);
    end
    drive(1'b0, 1'b1, 16'd32767, 1'b0, 9'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || theta !== 9'd127 || step_inc !== 1'b0) begin
      errors++;
      $display("FAIL load_frac got %h want %h", obs, exp_v);
    end
    drive(1'b0, 1'b1, 16'd32767, 1'b0, 9'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || theta !== 9'd128 || hall_uvw !== 3'b011 || step_inc !== 1'b1) begin
      errors++;
      $display("FAIL load_step got %h theta=%0d hall=%b inc=%b want %h 128 011 1",
               obs, theta, hall_uvw, step_inc, exp_v);
    end
  endtask

  task automatic test_hold();
    logic [16:0] snap;
    int n_chg = 0;
    drive(1'b0, 1'b0, 16'd0, 1'b1, 9'd300);
    exp_v = exp_q.pop_front();
    snap = exp_v;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, 16'($urandom_range(0, 65535)), 1'b0, 9'($urandom_range(0, 511)));
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hold_sb cycle %0d got %h want %h", i, obs, exp_v);
      end
      if (obs !== snap) n_chg++;
    end
    checks++;
    if (n_chg != 0 || theta !== 9'd300 || hall_uvw !== 3'b101) begin
      errors++;
      $display("FAIL hold_frozen got %0d changes theta=%0d hall=%b want 0 300 101", n_chg, theta, hall_uvw);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 16'd32767, 1'b1, 9'd249);
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 16'd32767, 1'b0, 9'd0);
      exp_v = exp_q.pop_front();
    end
    checks++;
    if (theta !== 9'd250 || step_inc !== 1'b1) begin
      errors++;
      $display("FAIL resetmid_pre got theta=%0d inc=%b want 250 1", theta, step_inc);
    end
    drive(1'b1, 1'b1, 16'd32767, 1'b0, 9'd0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || obs !== {9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110}) begin
      errors++;
      $display("FAIL resetmid got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
            16'($urandom_range(0, 65535)), ($urandom_range(0, 9) == 0),
            9'($urandom_range(0, 511)));
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_sb cycle %0d got %h want %h", i, obs, exp_v);
      end
      if (step_inc && step_dec) begin
        errors++;
        $display("FAIL step_both got inc=1 dec=1 want not both");
      end
    end
  endtask

`ifdef MOTOR_SENSOR_EMULATOR_FAULT_EN
  task automatic test_fault();
    logic [1:0] modes[5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
    drive(1'b0, 1'b1, 16'd0, 1'b1, 9'd30);
    exp_v = exp_q.pop_front();
    for (int m = 0; m < 5; m++) begin
      fault_mode = modes[m];
      for (int i = 0; i < 40; i++) begin
        drive(1'b0, 1'b1, 16'd20000, 1'b0, 9'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL fault_sb mode %b cycle %0d got %h want %h", modes[m], i, obs, exp_v);
        end
        if (modes[m] == 2'b01 && hall_uvw !== 3'b000) begin
          errors++;
          $display("FAIL fault_force got hall=%b want 000", hall_uvw);
        end
      end
    end
    fault_mode = 2'b00;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; speed = '0; load_valid = 1'b0; load_theta = '0;
    fault_mode = 2'b00;
    test_reset();
    test_rotation();
    test_neg_saturation();
    test_load();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef MOTOR_SENSOR_EMULATOR_FAULT_EN
    test_fault();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got no completion want finish before 5ms");
    $fatal(1, "timeout");
  end

endmodule
